csa_accum_stream: RTL

Streaming multi-operand accumulator built on carry-save reduction. Accepts a packet of W-bit operands, one per beat, over a valid/ready handshake. Each operand is folded into a redundant sum/carry pair by one 3:2 compressor row, so no carry propagates per beat. On end of packet, one carry-propagate add resolves the total. Used as the generalised successor to the fixed 4-bit, 3-operand carry-save adder: arbitrary width, arbitrary operand count, signed mode, handshaking.

---
 rtl/csa_pkg.sv | 22 ++
 rtl/csa_accum_stream_if.sv | 31 +++
 rtl/csa_row.sv | 17 +
 rtl/csa_accum_stream.sv | 118 +++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save streaming accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  function automatic int csa_clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/csa_accum_stream_if.sv
// Operand input stream and result output stream of the accumulator.
interface csa_accum_stream_if
  import csa_pkg::*;
#(
  parameter int W         = 8,
  parameter int MAX_TERMS = 16
);
  localparam int ACC_W = W + csa_clog2(MAX_TERMS);
  localparam int CNT_W = csa_clog2(MAX_TERMS) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_trunc;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_trunc
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_trunc
  );

endinterface

// File: rtl/csa_row.sv
// One row of full adders used as a 3:2 compressor; carry is returned unshifted.
module csa_row #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign sum[gi]   = a[gi] ^ b[gi] ^ c[gi];
    assign carry[gi] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
  end

endmodule

// File: rtl/csa_accum_stream.sv
// Streaming multi-operand accumulator: per-beat carry-save fold, one
// carry-propagate add per packet.
module csa_accum_stream
  import csa_pkg::*;
#(
  parameter int W         = 8,
  parameter int MAX_TERMS = 16,
  parameter int SIGNED    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  csa_accum_stream_if.slave  bus
);

  localparam int ACC_W = W + csa_clog2(MAX_TERMS);
  localparam int CNT_W = csa_clog2(MAX_TERMS) + 1;

  state_t           state_reg;
  state_t           state_next;

  logic [ACC_W-1:0] sum_reg;
  logic [ACC_W-1:0] carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             trunc_reg;
  logic [ACC_W-1:0] out_sum_reg;
  logic [CNT_W-1:0] out_count_reg;
  logic             out_trunc_reg;

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] row_sum;
  logic [ACC_W-1:0] row_carry;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             accept;
  logic             term_limit;
  logic             close;

  if (SIGNED != 0) begin : g_sext
    assign ext = {{(ACC_W-W){bus.in_data[W-1]}}, bus.in_data};
  end else begin : g_zext
    assign ext = {{(ACC_W-W){1'b0}}, bus.in_data};
  end

  csa_row #(
    .WIDTH (ACC_W)
  ) u_row (
    .a     (sum_reg),
    .b     (carry_reg),
    .c     (ext),
    .sum   (row_sum),
    .carry (row_carry)
  );

  assign accept     = bus.in_valid & in_ready_c;
  assign term_limit = (cnt_reg == CNT_W'(MAX_TERMS - 1));
  assign close      = accept & (bus.in_last | term_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_ACC;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ACC:     if (close) state_next = ST_RESOLVE;
      ST_RESOLVE: state_next = ST_HOLD;
      ST_HOLD:    if (bus.out_ready) state_next = ST_ACC;
      default:    state_next = ST_ACC;
    endcase
  end

  // Result is presented for exactly the cycles spent in HOLD.
  always_comb begin
    in_ready_c  = (state_reg == ST_ACC);
    out_valid_c = (state_reg == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg       <= '0;
      carry_reg     <= '0;
      cnt_reg       <= '0;
      trunc_reg     <= 1'b0;
      out_sum_reg   <= '0;
      out_count_reg <= '0;
      out_trunc_reg <= 1'b0;
    end else begin
      if (accept) begin
        sum_reg   <= row_sum;
        // Shift drops the top carry, so the accumulator wraps modulo 2^ACC_W.
        carry_reg <= row_carry << 1;
        cnt_reg   <= cnt_reg + CNT_W'(1);
        if (close) begin
          trunc_reg <= ~bus.in_last;
        end
      end
      if (state_reg == ST_RESOLVE) begin
        out_sum_reg   <= sum_reg + carry_reg;
        out_count_reg <= cnt_reg;
        out_trunc_reg <= trunc_reg;
        sum_reg       <= '0;
        carry_reg     <= '0;
        cnt_reg       <= '0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_sum   = out_sum_reg;
  assign bus.out_count = out_count_reg;
  assign bus.out_trunc = out_trunc_reg;

endmodule
